// File: rtl/fp_addsub_exc_unit_pkg.sv
// Shared definitions for the FP add/sub exception stage.
// Holds the flag bit positions, the rounding-mode enum, and helpers that
// build special encodings (qNaN, infinity, largest finite) for any format.
// The helpers return 64 bits; callers cast the result down to the format width.
package fp_exc_pkg;

    localparam int unsigned FLAG_W = 5;
    localparam int unsigned OF     = 4;
    localparam int unsigned UF     = 3;
    localparam int unsigned DZ     = 2;
    localparam int unsigned NV     = 1;
    localparam int unsigned NX     = 0;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rnd_mode_e;

    // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB only.
    function automatic logic [63:0] qnan(input int unsigned exp_w, input int unsigned man_w);
        logic [63:0] e_ones;
        e_ones = (64'(1) << exp_w) - 64'(1);
        return (e_ones << man_w) | (64'(1) << (man_w - 1));
    endfunction

    // Signed infinity: exponent all ones, mantissa zero.
    function automatic logic [63:0] inf(input logic s, input int unsigned exp_w,
                                        input int unsigned man_w);
        logic [63:0] e_ones;
        e_ones = (64'(1) << exp_w) - 64'(1);
        return (64'(s) << (exp_w + man_w)) | (e_ones << man_w);
    endfunction

    // Signed largest finite: exponent all ones minus one, mantissa all ones.
    function automatic logic [63:0] maxfin(input logic s, input int unsigned exp_w,
                                           input int unsigned man_w);
        logic [63:0] e_ones;
        e_ones = (64'(1) << exp_w) - 64'(1);
        return (64'(s) << (exp_w + man_w)) | ((e_ones - 64'(1)) << man_w)
             | ((64'(1) << man_w) - 64'(1));
    endfunction

endpackage

// File: rtl/fp_addsub_exc_unit_if.sv
// Upstream/downstream handshake bundle of the exception stage.
// slave  : the stage itself (accepts in_*, produces out_*)
// master : the environment (rounding stage on input, writeback on output)
interface fp_addsub_exc_unit_if
    import fp_exc_pkg::*;
#(
    parameter int unsigned W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_z;
    logic              in_nege;
    logic              in_r;
    logic              in_s;
    logic [4:0]        in_exc;
    logic              in_eof;
    rnd_mode_e         rnd_mode;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_p;
    logic [FLAG_W-1:0] out_flags;

    modport slave (
        input  in_valid, in_z, in_nege, in_r, in_s, in_exc, in_eof, rnd_mode, out_ready,
        output in_ready, out_valid, out_p, out_flags
    );

    modport master (
        output in_valid, in_z, in_nege, in_r, in_s, in_exc, in_eof, rnd_mode, out_ready,
        input  in_ready, out_valid, out_p, out_flags
    );
endinterface

// File: rtl/fp_addsub_exc_unit_override.sv
// Combinational exception classification and result override.
// Ports: z/nege/r/s/exc/eof/rnd_mode describe the rounded result;
//        p_c is the final result, flags_c is {OF,UF,DZ,NV,NX}.
module fp_exc_override
    import fp_exc_pkg::*;
#(
    parameter int unsigned EXP_W = 3,
    parameter int unsigned MAN_W = 4,
    parameter bit          FTZ   = 1'b1,
    localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0]      z,
    input  logic              nege,
    input  logic              r,
    input  logic              s,
    input  logic [4:0]        exc,
    input  logic              eof,
    input  rnd_mode_e         rnd_mode,
    output logic [W-1:0]      p_c,
    output logic [FLAG_W-1:0] flags_c
);
    logic nv;
    logic inf_op;
    logic of;
    logic uf;
    logic sign;

    // An infinite operand yields an exact infinity, so it masks overflow.
    assign nv     = |exc[4:2];
    assign inf_op = |exc[1:0];
    assign of     = eof & ~nv & ~inf_op;
    assign uf     = nege & (r | s) & ~nv;
    assign sign   = z[W-1];

    always_comb begin
        flags_c     = '0;
        flags_c[OF] = of;
        flags_c[UF] = uf;
        flags_c[NV] = nv;
        flags_c[NX] = r | s | of | uf;
    end

    // Result override in priority order: NaN, infinite operand, overflow, FTZ.
    always_comb begin
        p_c = z;
        if (nv) begin
            p_c = W'(qnan(EXP_W, MAN_W));
        end else if (inf_op) begin
            p_c = z;
        end else if (of) begin
            case (rnd_mode)
                RM_RNE:  p_c = W'(inf(sign, EXP_W, MAN_W));
                RM_RTZ:  p_c = W'(maxfin(sign, EXP_W, MAN_W));
                RM_RUP:  p_c = sign ? W'(maxfin(1'b1, EXP_W, MAN_W)) : W'(inf(1'b0, EXP_W, MAN_W));
                RM_RDN:  p_c = sign ? W'(inf(1'b1, EXP_W, MAN_W)) : W'(maxfin(1'b0, EXP_W, MAN_W));
                default: p_c = W'(inf(sign, EXP_W, MAN_W));
            endcase
        end else if (uf && FTZ) begin
            p_c = {sign, {(W-1){1'b0}}};
        end
    end
endmodule

// File: rtl/fp_addsub_exc_unit.sv
// Registered exception stage at the tail of the FP add/sub datapath.
// Ports: clk, rst_n (sync, active low); bus = in/out valid-ready handshake;
//        flag_clr/trap_en/sticky_flags/trap = software flag interface;
//        cnt_clr/exc_count = saturating count of OF|UF|NV results.
module fp_addsub_exc_unit
    import fp_exc_pkg::*;
#(
    parameter int unsigned EXP_W = 3,
    parameter int unsigned MAN_W = 4,
    parameter bit          FTZ   = 1'b1,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_addsub_exc_unit_if.slave bus,
    input  logic [FLAG_W-1:0] flag_clr,
    input  logic [FLAG_W-1:0] trap_en,
    output logic [FLAG_W-1:0] sticky_flags,
    output logic              trap,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  exc_count
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic [W-1:0]      p_c;
    logic [FLAG_W-1:0] flags_c;
    logic              acc;
    logic              counted;
    logic              out_valid_q;
    logic [W-1:0]      out_p_q;
    logic [FLAG_W-1:0] out_flags_q;

    fp_exc_override #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .FTZ   (FTZ)
    ) u_override (
        .z        (bus.in_z),
        .nege     (bus.in_nege),
        .r        (bus.in_r),
        .s        (bus.in_s),
        .exc      (bus.in_exc),
        .eof      (bus.in_eof),
        .rnd_mode (bus.rnd_mode),
        .p_c      (p_c),
        .flags_c  (flags_c)
    );

    // Accept whenever the output slot is empty or being drained this cycle.
    assign bus.in_ready  = ~out_valid_q | bus.out_ready;
    assign acc           = bus.in_valid & bus.in_ready;
    assign counted       = flags_c[OF] | flags_c[UF] | flags_c[NV];
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
    assign bus.out_flags = out_flags_q;
    assign trap          = |(sticky_flags & trap_en);

    // Output register: load on accept, drop valid when drained without refill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            out_flags_q <= '0;
        end else if (acc) begin
            out_valid_q <= 1'b1;
            out_p_q     <= p_c;
            out_flags_q <= flags_c;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Sticky flags: setting by an accepted op wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_flags <= '0;
        end else begin
            sticky_flags <= (sticky_flags & ~flag_clr) | (acc ? flags_c : '0);
        end
    end

    // Saturating exception counter; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exc_count <= '0;
        end else if (cnt_clr) begin
            exc_count <= '0;
        end else if (acc && counted && (exc_count != {CNT_W{1'b1}})) begin
            exc_count <= exc_count + CNT_W'(1);
        end
    end
endmodule
